// File: rtl/reminder_pkg.sv
// Shared types, digit layout and load validation for the water-reminder countdown.
package reminder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  localparam int S0_LSB = 0;
  localparam int S1_LSB = 4;
  localparam int M0_LSB = 8;
  localparam int M1_LSB = 12;
  localparam int H0_LSB = 16;
  localparam int H1_LSB = 20;

  localparam logic [3:0] S0_MAX = 4'd9;
  localparam logic [3:0] S1_MAX = 4'd5;
  localparam logic [3:0] M0_MAX = 4'd9;
  localparam logic [3:0] M1_MAX = 4'd5;
  localparam logic [3:0] H0_MAX = 4'd9;
  localparam logic [3:0] H1_MAX = 4'd2;

  localparam logic [3:0] HOUR_MAX_TENS       = 4'd2;
  localparam logic [3:0] HOUR_MAX_UNITS_AT_2 = 4'd3;

  // True when d is a legal HH:MM:SS value no later than 23:59:59.
  function automatic logic bcd_time_valid(input logic [23:0] d);
    logic [3:0] s0, s1, m0, m1, h0, h1;
    logic       hours_ok;
    s0 = d[S0_LSB +: 4];
    s1 = d[S1_LSB +: 4];
    m0 = d[M0_LSB +: 4];
    m1 = d[M1_LSB +: 4];
    h0 = d[H0_LSB +: 4];
    h1 = d[H1_LSB +: 4];
    hours_ok = (h1 < HOUR_MAX_TENS) ||
               ((h1 == HOUR_MAX_TENS) && (h0 <= HOUR_MAX_UNITS_AT_2));
    return (s0 <= S0_MAX) && (s1 <= S1_MAX) && (m0 <= M0_MAX) &&
           (m1 <= M1_MAX) && (h0 <= H0_MAX) && hours_ok;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the borrow chain: decrements when borrow_in is set, wrapping to MAX.
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic [3:0] cur,
  input  logic       borrow_in,
  output logic [3:0] nxt,
  output logic       borrow_out
);

  always_comb begin
    nxt        = cur;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (cur == 4'd0) begin
        nxt        = MAX;
        borrow_out = 1'b1;
      end else begin
        nxt = cur - 4'd1;
      end
    end
  end

endmodule

// File: rtl/reminder_countdown.sv
// HH:MM:SS BCD countdown with alarm. Define REMINDER_AUTO_RELOAD_EN to make ack
// restart the countdown from the reload value instead of returning to IDLE.
module reminder_countdown
  import reminder_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] set_digits,
  input  logic        load,
  input  logic        start,
  input  logic        pause,
  input  logic        ack,
  output logic [23:0] count_digits,
  output logic        sec_tick,
  output logic        running,
  output logic        alarm,
  output logic        load_err
);

  localparam int             PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  TICK_MAX = PW'(TICK_DIV - 1);

  state_t         r_state;
  logic [23:0]    r_count;
  logic [23:0]    r_reload;
  logic [PW-1:0]  r_presc;
  logic           r_load_err;

  logic [23:0]    w_dec;
  logic [6:0]     w_borrow;
  logic           w_tick;
  logic           w_load_ok;

  assign w_borrow[0] = 1'b1;

  // Seconds-first borrow chain; borrow out of the hour tens means underflow.
  bcd_down_digit #(.MAX(S0_MAX)) u_s0 (.cur(r_count[S0_LSB +: 4]), .borrow_in(w_borrow[0]),
                                       .nxt(w_dec[S0_LSB +: 4]), .borrow_out(w_borrow[1]));
  bcd_down_digit #(.MAX(S1_MAX)) u_s1 (.cur(r_count[S1_LSB +: 4]), .borrow_in(w_borrow[1]),
                                       .nxt(w_dec[S1_LSB +: 4]), .borrow_out(w_borrow[2]));
  bcd_down_digit #(.MAX(M0_MAX)) u_m0 (.cur(r_count[M0_LSB +: 4]), .borrow_in(w_borrow[2]),
                                       .nxt(w_dec[M0_LSB +: 4]), .borrow_out(w_borrow[3]));
  bcd_down_digit #(.MAX(M1_MAX)) u_m1 (.cur(r_count[M1_LSB +: 4]), .borrow_in(w_borrow[3]),
                                       .nxt(w_dec[M1_LSB +: 4]), .borrow_out(w_borrow[4]));
  bcd_down_digit #(.MAX(H0_MAX)) u_h0 (.cur(r_count[H0_LSB +: 4]), .borrow_in(w_borrow[4]),
                                       .nxt(w_dec[H0_LSB +: 4]), .borrow_out(w_borrow[5]));
  bcd_down_digit #(.MAX(H1_MAX)) u_h1 (.cur(r_count[H1_LSB +: 4]), .borrow_in(w_borrow[5]),
                                       .nxt(w_dec[H1_LSB +: 4]), .borrow_out(w_borrow[6]));

  assign w_tick    = (r_state == RUN) && (r_presc == TICK_MAX);
  assign w_load_ok = bcd_time_valid(set_digits);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_reload   <= '0;
      r_presc    <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= 1'b0;
      unique case (r_state)
        IDLE, PAUSE: begin
          if (load) begin
            if (w_load_ok) begin
              r_reload <= set_digits;
              r_count  <= set_digits;
              r_presc  <= '0;
            end else begin
              r_load_err <= 1'b1;
            end
          end else if (!pause && start && (r_count != 24'd0)) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          // Pause freezes the prescaler so a resume finishes the partial second.
          if (pause) begin
            r_state <= PAUSE;
          end else if (w_tick) begin
            r_presc <= '0;
            if (!w_borrow[6]) begin
              r_count <= w_dec;
              if (w_dec == 24'd0) r_state <= ALARM;
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
        ALARM: begin
          r_count <= '0;
          r_presc <= '0;
          if (ack) begin
            r_count <= r_reload;
`ifdef REMINDER_AUTO_RELOAD_EN
            r_state <= (r_reload != 24'd0) ? RUN : IDLE;
`else
            r_state <= IDLE;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign count_digits = r_count;
  assign sec_tick     = w_tick;
  assign running      = (r_state == RUN);
  assign alarm        = (r_state == ALARM);
  assign load_err     = r_load_err;

endmodule

// File: tb/tb_reminder_countdown.sv
// Directed bench for reminder_countdown at TICK_DIV=4; follows REMINDER_AUTO_RELOAD_EN if defined.
module tb_reminder_countdown;

  logic        clk;
  logic        reset;
  logic [23:0] set_digits;
  logic        load, start, pause, ack;
  logic [23:0] count_digits;
  logic        sec_tick, running, alarm, load_err;

  int n_tests;
  int n_fail;

  reminder_countdown #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .set_digits(set_digits), .load(load),
    .start(start), .pause(pause), .ack(ack), .count_digits(count_digits),
    .sec_tick(sec_tick), .running(running), .alarm(alarm), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step(1);
  endtask

  task automatic do_load(input logic [23:0] v);
    set_digits = v;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    set_digits = '0;
    load = 0; start = 0; pause = 0; ack = 0;
    #3;
    check_eq("rst_count", count_digits, 24'h0);
    check_eq("rst_running", 24'(running), 24'h0);
    check_eq("rst_alarm", 24'(alarm), 24'h0);
    check_eq("rst_tick", 24'(sec_tick), 24'h0);
    check_eq("rst_lerr", 24'(load_err), 24'h0);
    step(1);
    reset = 1'b0;
    step(1);

    // Basic countdown from 00:00:03
    do_load(24'h000003);
    check_eq("ld3_count", count_digits, 24'h000003);
    check_eq("ld3_lerr", 24'(load_err), 24'h0);
    do_start();
    check_eq("st3_running", 24'(running), 24'h1);
    for (int k = 1; k <= 3; k++) begin
      step(2);
      check_eq("pre_tick_low", 24'(sec_tick), 24'h0);
      step(1);
      check_eq("tick_high", 24'(sec_tick), 24'h1);
      check_eq("tick_hold", count_digits, 24'(4 - k));
      step(1);
      check_eq("dec_count", count_digits, 24'(3 - k));
    end
    check_eq("alarm_set", 24'(alarm), 24'h1);
    check_eq("alarm_notrun", 24'(running), 24'h0);
    check_eq("alarm_notick", 24'(sec_tick), 24'h0);
    start = 1'b1; pause = 1'b1;
    step(3);
    start = 1'b0; pause = 1'b0;
    check_eq("alarm_hold", count_digits, 24'h0);
    check_eq("alarm_stays", 24'(alarm), 24'h1);
    do_reset();

    // Alarm from 00:00:02 then ack
    do_load(24'h000002);
    do_start();
    step(8);
    check_eq("a2_alarm", 24'(alarm), 24'h1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check_eq("ack_count", count_digits, 24'h000002);
    check_eq("ack_alarm", 24'(alarm), 24'h0);
`ifdef REMINDER_AUTO_RELOAD_EN
    check_eq("ack_running", 24'(running), 24'h1);
    step(3);
    check_eq("ack_tick", 24'(sec_tick), 24'h1);
    step(1);
    check_eq("ack_dec", count_digits, 24'h000001);
`else
    check_eq("ack_running", 24'(running), 24'h0);
    step(4);
    check_eq("ack_idle_hold", count_digits, 24'h000002);
`endif
    do_reset();

    // Borrow chain 10:00:00 -> 09:59:59
    do_load(24'h100000);
    do_start();
    step(3);
    check_eq("brw_before", count_digits, 24'h100000);
    step(1);
    check_eq("brw_after", count_digits, 24'h095959);
    do_reset();

    // Invalid loads and boundary valid load
    do_load(24'h006000);
    check_eq("inv_lerr", 24'(load_err), 24'h1);
    check_eq("inv_count", count_digits, 24'h0);
    step(1);
    check_eq("inv_lerr_clr", 24'(load_err), 24'h0);
    do_start();
    check_eq("inv_start_idle", 24'(running), 24'h0);
    do_load(24'h240000);
    check_eq("inv24_lerr", 24'(load_err), 24'h1);
    check_eq("inv24_count", count_digits, 24'h0);
    do_load(24'h235959);
    check_eq("max_lerr", 24'(load_err), 24'h0);
    check_eq("max_count", count_digits, 24'h235959);
    do_reset();

    // Pause holds prescaler, resume finishes the partial second
    do_load(24'h000005);
    do_start();
    step(2);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    check_eq("pse_running", 24'(running), 24'h0);
    step(10);
    check_eq("pse_count", count_digits, 24'h000005);
    check_eq("pse_tick", 24'(sec_tick), 24'h0);
    do_start();
    check_eq("res_running", 24'(running), 24'h1);
    check_eq("res_count", count_digits, 24'h000005);
    step(1);
    check_eq("res_tick", 24'(sec_tick), 24'h1);
    step(1);
    check_eq("res_dec", count_digits, 24'h000004);
    do_reset();

    // Asynchronous reset mid-run
    do_load(24'h000105);
    do_start();
    step(2);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_count", count_digits, 24'h0);
    check_eq("arst_running", 24'(running), 24'h0);
    check_eq("arst_alarm", 24'(alarm), 24'h0);
    #1;
    reset = 1'b0;
    step(1);
    do_start();
    check_eq("arst_start_ign", 24'(running), 24'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
